// File: rtl/cfg_pkg.sv
// Shared types and sizing helpers for the LUT configuration-chain loader.
package cfg_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } cfg_state_t;

   localparam int DEF_CONFIG_WIDTH = 1;
   localparam int DEF_WORD_WIDTH   = 8;
   localparam int DEF_CHAIN_BITS   = 16;

   function automatic int chunks_per_word(input int cw, input int ww);
      return ww / cw;
   endfunction

   function automatic int total_chunks(input int cw, input int bits);
      return bits / cw;
   endfunction

   function automatic int num_words(input int ww, input int bits);
      return (bits + ww - 1) / ww;
   endfunction

   // Width of a counter that must hold the values 0..n inclusive.
   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/cfg_word_serializer.sv
// One-word buffer that presents CONFIG_WIDTH-bit chunks LSB first; the low
// chunk of the buffer is the chain data, so the output comes straight off flops.
module cfg_word_serializer
   import cfg_pkg::*;
#(
   parameter int CONFIG_WIDTH = DEF_CONFIG_WIDTH,
   parameter int WORD_WIDTH   = DEF_WORD_WIDTH
)
(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    i_load,
   input  logic [WORD_WIDTH-1:0]   i_word,
   input  logic                    i_flush,
   output logic                    o_full,
   output logic                    o_last,
   output logic [CONFIG_WIDTH-1:0] o_chunk
);

   localparam int CHUNKS_PER_WORD = chunks_per_word(CONFIG_WIDTH, WORD_WIDTH);
   localparam int IDX_W           = (CHUNKS_PER_WORD > 1) ? $clog2(CHUNKS_PER_WORD) : 1;

   logic [WORD_WIDTH-1:0] r_buf;
   logic [IDX_W-1:0]      r_idx;
   logic                  r_full;

   // The last chunk is not shifted away, so the chain data holds during a stall.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_buf  <= '0;
         r_idx  <= '0;
         r_full <= 1'b0;
      end else if (i_flush) begin
         r_idx  <= '0;
         r_full <= 1'b0;
      end else if (i_load) begin
         r_buf  <= i_word;
         r_idx  <= '0;
         r_full <= 1'b1;
      end else if (r_full) begin
         if (o_last) begin
            r_full <= 1'b0;
         end else begin
            r_buf <= r_buf >> CONFIG_WIDTH;
            r_idx <= r_idx + 1'b1;
         end
      end
   end

   assign o_full  = r_full;
   assign o_last  = r_full && (r_idx == IDX_W'(CHUNKS_PER_WORD - 1));
   assign o_chunk = r_buf[CONFIG_WIDTH-1:0];

endmodule

// File: rtl/cfg_chain_loader.sv
// Serialises a word-wide bitstream into the LUT config shift chain.
// Optional CFG_READBACK_EN adds cfg_tail capture (rb_data/rb_valid) for verify.
module cfg_chain_loader
   import cfg_pkg::*;
#(
   parameter int CONFIG_WIDTH = DEF_CONFIG_WIDTH,
   parameter int WORD_WIDTH   = DEF_WORD_WIDTH,
   parameter int CHAIN_BITS   = DEF_CHAIN_BITS
)
(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic                    abort,
   input  logic [WORD_WIDTH-1:0]   word_in,
   input  logic                    word_valid,
   output logic                    word_ready,
   output logic                    cfg_en,
   output logic [CONFIG_WIDTH-1:0] cfg_out,
   output logic                    busy,
   output logic                    done
`ifdef CFG_READBACK_EN
   ,
   input  logic [CONFIG_WIDTH-1:0] cfg_tail,
   output logic [CONFIG_WIDTH-1:0] rb_data,
   output logic                    rb_valid
`endif
);

   localparam int TOTAL_CHUNKS = total_chunks(CONFIG_WIDTH, CHAIN_BITS);
   localparam int NUM_WORDS    = num_words(WORD_WIDTH, CHAIN_BITS);
   localparam int SC_W         = cnt_width(TOTAL_CHUNKS);
   localparam int WC_W         = cnt_width(NUM_WORDS);

   cfg_state_t       r_state;
   cfg_state_t       w_state_nxt;
   logic [SC_W-1:0]  r_shift_cnt;
   logic [WC_W-1:0]  r_word_cnt;
   logic             w_accept;
   logic             w_last_shift;
   logic             w_flush;
   logic             w_buf_full;
   logic             w_buf_last;
   logic [CONFIG_WIDTH-1:0] w_chunk;

   // Handshake: a word transfers on a rising edge where word_valid && word_ready.
   // word_ready is combinational and never depends on word_valid.
   assign word_ready = (r_state == ST_LOAD) && (r_word_cnt != WC_W'(NUM_WORDS))
                       && (!w_buf_full || w_buf_last);
   assign w_accept     = word_valid && word_ready;
   assign w_last_shift = cfg_en && (r_shift_cnt == SC_W'(TOTAL_CHUNKS - 1));
   // Stopping at the final chain chunk also drops unused chunks of a partial word.
   assign w_flush      = (r_state == ST_LOAD) && (abort || w_last_shift);

   cfg_word_serializer #(
      .CONFIG_WIDTH (CONFIG_WIDTH),
      .WORD_WIDTH   (WORD_WIDTH)
   ) u_ser (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_load  (w_accept),
      .i_word  (word_in),
      .i_flush (w_flush),
      .o_full  (w_buf_full),
      .o_last  (w_buf_last),
      .o_chunk (w_chunk)
   );

   assign cfg_en  = w_buf_full;
   assign cfg_out = w_chunk;

   always_comb begin
      w_state_nxt = r_state;
      busy        = 1'b0;
      done        = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) w_state_nxt = ST_LOAD;
         end
         ST_LOAD: begin
            busy = 1'b1;
            if (abort)             w_state_nxt = ST_IDLE;
            else if (w_last_shift) w_state_nxt = ST_DONE;
         end
         ST_DONE: begin
            done        = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_shift_cnt <= '0;
         r_word_cnt  <= '0;
      end else begin
         r_state <= w_state_nxt;
         if ((r_state == ST_IDLE) && start) begin
            r_shift_cnt <= '0;
            r_word_cnt  <= '0;
         end else begin
            if (cfg_en && (r_shift_cnt != SC_W'(TOTAL_CHUNKS)))
               r_shift_cnt <= r_shift_cnt + 1'b1;
            if (w_accept)
               r_word_cnt <= r_word_cnt + 1'b1;
         end
      end
   end

`ifdef CFG_READBACK_EN
   logic [CONFIG_WIDTH-1:0] r_rb_data;
   logic                    r_rb_valid;

   // Each enable pushes the chain one step, so cfg_tail yields the old contents oldest first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rb_data  <= '0;
         r_rb_valid <= 1'b0;
      end else begin
         r_rb_valid <= cfg_en;
         if (cfg_en) r_rb_data <= cfg_tail;
      end
   end

   assign rb_data  = r_rb_data;
   assign rb_valid = r_rb_valid;
`endif

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Bench for cfg_chain_loader: a 16-bit and a 12-bit chain instance share stimulus,
// outputs are observed through a select mux and compared with a bitstream model.
module tb_cfg_chain_loader;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic       word_valid = 1'b0;
   logic [7:0] word_in = 8'h00;
   logic       sel_b = 1'b0;
   logic       preload = 1'b0;

   logic       ready_a, en_a, busy_a, done_a;
   logic [0:0] out_a;
   logic       ready_b, en_b, busy_b, done_b;
   logic [0:0] out_b;

   logic [15:0] chain_a = 16'h0000;
   logic [11:0] chain_b = 12'h000;

   int chk_cnt = 0;
   int pass_cnt = 0;
   int cyc = 0;
   int done_cnt = 0;
   int done_cyc = 0;
   int first_en_cyc = 0;
   int last_en_cyc = 0;
   int acc_cyc = 0;
   logic [0:0] got_q[$];
   logic [0:0] exp_q[$];
   logic [0:0] rb_q[$];

   wire       m_ready = sel_b ? ready_b : ready_a;
   wire       m_en    = sel_b ? en_b    : en_a;
   wire [0:0] m_out   = sel_b ? out_b   : out_a;
   wire       m_busy  = sel_b ? busy_b  : busy_a;
   wire       m_done  = sel_b ? done_b  : done_a;
   wire [15:0] m_chain = sel_b ? {4'h0, chain_b} : chain_a;

`ifdef CFG_READBACK_EN
   logic [0:0] rb_data_a, rb_data_b;
   logic       rb_valid_a, rb_valid_b;
`endif

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- DUTs ----------------
   cfg_chain_loader #(.CONFIG_WIDTH(1), .WORD_WIDTH(8), .CHAIN_BITS(16)) dut_a (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start & ~sel_b),
      .abort      (abort & ~sel_b),
      .word_in    (word_in),
      .word_valid (word_valid),
      .word_ready (ready_a),
      .cfg_en     (en_a),
      .cfg_out    (out_a),
      .busy       (busy_a),
      .done       (done_a)
`ifdef CFG_READBACK_EN
      ,
      .cfg_tail   (chain_a[0:0]),
      .rb_data    (rb_data_a),
      .rb_valid   (rb_valid_a)
`endif
   );

   cfg_chain_loader #(.CONFIG_WIDTH(1), .WORD_WIDTH(8), .CHAIN_BITS(12)) dut_b (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start & sel_b),
      .abort      (abort & sel_b),
      .word_in    (word_in),
      .word_valid (word_valid),
      .word_ready (ready_b),
      .cfg_en     (en_b),
      .cfg_out    (out_b),
      .busy       (busy_b),
      .done       (done_b)
`ifdef CFG_READBACK_EN
      ,
      .cfg_tail   (chain_b[0:0]),
      .rb_data    (rb_data_b),
      .rb_valid   (rb_valid_b)
`endif
   );

   // LUT chains: data enters at the head, so the first chunk ends at bit 0 (tail).
   always @(posedge clk) begin
      if (preload) begin
         chain_a <= 16'hFFFF;
      end else begin
         if (en_a) chain_a <= {out_a, chain_a[15:1]};
         if (en_b) chain_b <= {out_b, chain_b[11:1]};
      end
   end

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (m_en) begin
         if (got_q.size() == 0) first_en_cyc = cyc;
         got_q.push_back(m_out);
         last_en_cyc = cyc;
      end
      if (m_done) begin
         done_cnt = done_cnt + 1;
         done_cyc = cyc;
      end
`ifdef CFG_READBACK_EN
      if (rb_valid_a && !sel_b) rb_q.push_back(rb_data_a);
`endif
   end

   // ---------------- scoreboard helpers ----------------
   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt = chk_cnt + 1;
      if (got === exp) pass_cnt = pass_cnt + 1;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
   endtask

   // ---------------- driver tasks ----------------
   task automatic pulse_start();
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Waits for word_ready, then holds word_valid low for 'gap' ready cycles.
   task automatic send_word(input logic [7:0] w, input int gap);
      int n;
      n = 0;
      word_valid = 1'b0;
      @(negedge clk);
      while (!m_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("word_ready_seen", (n < 200), 1);
      repeat (gap) @(negedge clk);
      word_in    = w;
      word_valid = 1'b1;
      acc_cyc    = cyc;
      @(posedge clk); #1;
      word_valid = 1'b0;
   endtask

   task automatic do_load(input bit b, input logic [7:0] w0, input logic [7:0] w1, input int gap,
                          input logic [15:0] exp_chain, input int exp_en, input int exp_stall,
                          input string tag);
      int d0, n, first_acc, mism, nbits;
      logic [15:0] both;
      sel_b = b;
      nbits = b ? 12 : 16;
      both  = {w1, w0};
      exp_q.delete();
      for (int i = 0; i < nbits; i++) exp_q.push_back(both[i]);
      got_q.delete();
      d0 = done_cnt;
      pulse_start();
      send_word(w0, 0);
      first_acc = acc_cyc;
      check({tag, "_busy"}, m_busy, 1);
      send_word(w1, gap);
      @(negedge clk);
      check({tag, "_ready_after_last"}, m_ready, 0);
      n = 0;
      while (done_cnt == d0 && n < 100) begin
         @(negedge clk); #1;
         n++;
      end
      check({tag, "_done_seen"}, (done_cnt != d0), 1);
      repeat (2) @(negedge clk);
      #1;
      check({tag, "_done_pulses"}, done_cnt - d0, 1);
      check({tag, "_done_timing"}, done_cyc, last_en_cyc + 1);
      check({tag, "_first_latency"}, first_en_cyc, first_acc + 1);
      check({tag, "_enables"}, got_q.size(), exp_en);
      check({tag, "_stall"}, (last_en_cyc - first_en_cyc + 1) - got_q.size(), exp_stall);
      mism = 0;
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         if (got_q[i] !== exp_q[i]) mism++;
      check({tag, "_stream_mismatches"}, mism, 0);
      check({tag, "_chain"}, m_chain, exp_chain);
      check({tag, "_idle_busy"}, m_busy, 0);
      check({tag, "_idle_en"}, m_en, 0);
   endtask

   typedef struct {
      bit          sel;
      logic [7:0]  w0;
      logic [7:0]  w1;
      int          gap;
      logic [15:0] exp_chain;
      int          exp_en;
      int          exp_stall;
   } vec_t;

   vec_t vecs[5];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout after %0d checks, expected completion", chk_cnt);
      $fatal(1);
   end

   initial begin
      int d0;
      logic [7:0] rw0, rw1;
      bit rb;
      int rgap;
      logic [15:0] rchain;

      vecs[0] = '{1'b0, 8'hA5, 8'h3C, 0, 16'h3CA5, 16, 0};
      vecs[1] = '{1'b0, 8'hA5, 8'h3C, 3, 16'h3CA5, 16, 3};
      vecs[2] = '{1'b1, 8'hA5, 8'hF3, 0, 16'h03A5, 12, 0};
      vecs[3] = '{1'b0, 8'h00, 8'hFF, 1, 16'hFF00, 16, 1};
      vecs[4] = '{1'b1, 8'h0F, 8'hF0, 2, 16'h000F, 12, 2};

      // reset state
      repeat (3) @(negedge clk);
      check("rst_en_a", en_a, 0);
      check("rst_out_a", out_a, 0);
      check("rst_ready_a", ready_a, 0);
      check("rst_busy_a", busy_a, 0);
      check("rst_done_a", done_a, 0);
      check("rst_en_b", en_b, 0);
      check("rst_busy_b", busy_b, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // words outside LOAD are ignored
      word_in = 8'hFF;
      word_valid = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_ready", ready_a, 0);
      check("idle_en", en_a, 0);
      word_valid = 1'b0;

      // table-driven loads
      for (int i = 0; i < 5; i++)
         do_load(vecs[i].sel, vecs[i].w0, vecs[i].w1, vecs[i].gap, vecs[i].exp_chain,
                 vecs[i].exp_en, vecs[i].exp_stall, $sformatf("vec%0d", i));

      // start and abort together in IDLE: start wins; abort then returns to IDLE
      sel_b = 1'b0;
      d0 = done_cnt;
      @(posedge clk); #1;
      start = 1'b1; abort = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0;
      check("start_over_abort", busy_a, 1);
      @(posedge clk); #1;
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      check("abort_empty_busy", busy_a, 0);
      check("abort_empty_done", done_cnt - d0, 0);

      // second start ignored at shift 5, abort at shift 9
      got_q.delete();
      d0 = done_cnt;
      pulse_start();
      send_word(8'hA5, 0);
      repeat (5) begin @(posedge clk); #1; end
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("restart_busy", busy_a, 1);
      send_word(8'h3C, 0);
      @(posedge clk); #1;
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      check("abort_en", en_a, 0);
      check("abort_busy", busy_a, 0);
      check("abort_ready", ready_a, 0);
      repeat (10) begin @(posedge clk); #1; end
      check("abort_enables", got_q.size(), 10);
      check("abort_stall", (last_en_cyc - first_en_cyc + 1) - got_q.size(), 0);
      check("abort_no_done", done_cnt - d0, 0);
      do_load(1'b0, 8'hA5, 8'h3C, 0, 16'h3CA5, 16, 0, "after_abort");

      // asynchronous reset at shift 7
      got_q.delete();
      pulse_start();
      send_word(8'hA5, 0);
      repeat (7) begin @(posedge clk); #1; end
      check("pre_rst_ready", ready_a, 1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_en", en_a, 0);
      check("mid_rst_busy", busy_a, 0);
      check("mid_rst_ready", ready_a, 0);
      #2;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_rst_busy", busy_a, 0);
      check("post_rst_done", done_a, 0);
      do_load(1'b0, 8'h5A, 8'hC3, 0, 16'hC35A, 16, 0, "after_rst");

      // randomized loads against the bitstream model
      for (int k = 0; k < 16; k++) begin
         rb   = 1'($urandom_range(0, 1));
         rw0  = 8'($urandom_range(0, 255));
         rw1  = 8'($urandom_range(0, 255));
         rgap = $urandom_range(0, 4);
         rchain = {rw1, rw0};
         if (rb) rchain = rchain & 16'h0FFF;
         do_load(rb, rw0, rw1, rgap, rchain, rb ? 12 : 16, rgap, $sformatf("rnd%0d", k));
      end

`ifdef CFG_READBACK_EN
      sel_b = 1'b0;
      @(posedge clk); #1;
      preload = 1'b1;
      @(posedge clk); #1;
      preload = 1'b0;
      rb_q.delete();
      do_load(1'b0, 8'h00, 8'h00, 0, 16'h0000, 16, 0, "rb_ones");
      check("rb_ones_count", rb_q.size(), 16);
      d0 = 0;
      foreach (rb_q[i]) if (rb_q[i] !== 1'b1) d0++;
      check("rb_ones_values", d0, 0);
      rb_q.delete();
      do_load(1'b0, 8'h00, 8'h00, 0, 16'h0000, 16, 0, "rb_zeros");
      check("rb_zeros_count", rb_q.size(), 16);
      d0 = 0;
      foreach (rb_q[i]) if (rb_q[i] !== 1'b0) d0++;
      check("rb_zeros_values", d0, 0);
`endif

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
